// File: rtl/regfile_pkg.sv
// Shared definitions for the multi-port register file: FSM encoding and
// default geometry.
package regfile_pkg;

    typedef enum logic {
        ST_INIT = 1'b0,
        ST_RUN  = 1'b1
    } state_e;

    localparam int XLEN_DEF  = 32;
    localparam int NREGS_DEF = 32;
    localparam int NREAD_DEF = 2;

endpackage

// File: rtl/regfile_rd_port.sv
// One combinational read port: address decode, x0 zeroing, same-cycle
// write bypass and pending-flag lookup.
module regfile_rd_port
    import regfile_pkg::*;
#(
    parameter int XLEN  = XLEN_DEF,
    parameter int NREGS = NREGS_DEF,
    parameter int AW    = $clog2(NREGS)
) (
    input  logic                  run_i,
    input  logic [NREGS*XLEN-1:0] regs_flat_i,
    input  logic [NREGS-1:0]      busy_vec_i,
    input  logic [AW-1:0]         raddr_i,
    input  logic                  we_i,
    input  logic [AW-1:0]         waddr_i,
    input  logic [XLEN-1:0]       wdata_i,
    output logic [XLEN-1:0]       rdata_o,
    output logic                  rbusy_o
);

    logic [XLEN-1:0] stored_s;
    logic            addr_hit_s;

    // Select stored word, then apply zeroing and bypass priority.
    always_comb begin
        stored_s   = regs_flat_i[int'(raddr_i)*XLEN +: XLEN];
        addr_hit_s = we_i && (waddr_i == raddr_i);
        rdata_o    = '0;
        rbusy_o    = 1'b0;
        if (!run_i) begin
            rdata_o = '0;
            rbusy_o = 1'b0;
        end else if (raddr_i == '0) begin
            rdata_o = '0;
            rbusy_o = 1'b0;
        end else begin
            rdata_o = addr_hit_s ? wdata_i : stored_s;
            rbusy_o = busy_vec_i[raddr_i] && !addr_hit_s;
        end
    end

endmodule

// File: rtl/regfile_mp.sv
// Multi-port register file with an initialising sweep after reset and a
// per-register pending scoreboard.
module regfile_mp
    import regfile_pkg::*;
#(
    parameter int XLEN  = XLEN_DEF,
    parameter int NREGS = NREGS_DEF,
    parameter int NREAD = NREAD_DEF,
    parameter int AW    = $clog2(NREGS)
) (
    input  logic                  clk,
    input  logic                  rst,
    output logic                  ready,
    input  logic                  regWrite,
    input  logic [AW-1:0]         writeReg,
    input  logic [XLEN-1:0]       writeData,
    input  logic                  claim,
    input  logic [AW-1:0]         claimReg,
    input  logic [NREAD*AW-1:0]   readReg,
    output logic [NREAD*XLEN-1:0] readData,
    output logic [NREAD-1:0]      readBusy
);

    localparam logic [AW-1:0] LAST_IDX = AW'(NREGS - 1);

    state_e                state_q, state_d;
    logic [AW-1:0]         cnt_q, cnt_d;
    logic [NREGS-1:0]      busy_q, busy_d;
    logic [XLEN-1:0]       regs_q [NREGS];
    logic [NREGS*XLEN-1:0] regs_flat_s;
    logic                  run_s;
    logic                  we_s;

    assign run_s = (state_q == ST_RUN);
    assign we_s  = run_s && regWrite;
    assign ready = run_s;

    // Next-state for the sweep FSM, counter and scoreboard.
    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        busy_d  = busy_q;
        case (state_q)
            ST_INIT: begin
                busy_d = '0;
                cnt_d  = cnt_q + {{(AW-1){1'b0}}, 1'b1};
                if (cnt_q == LAST_IDX) begin
                    state_d = ST_RUN;
                end else begin
                    state_d = ST_INIT;
                end
            end
            ST_RUN: begin
                // Clear before set so a same-cycle claim keeps the bit pending.
                if (regWrite) begin
                    busy_d[writeReg] = 1'b0;
                end else begin
                    busy_d = busy_q;
                end
                if (claim && (claimReg != '0)) begin
                    busy_d[claimReg] = 1'b1;
                end else begin
                    busy_d[0] = 1'b0;
                end
            end
            default: begin
                state_d = ST_INIT;
                cnt_d   = '0;
                busy_d  = '0;
            end
        endcase
    end

    // Control registers with synchronous reset restarting the sweep.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= ST_INIT;
            cnt_q   <= '0;
            busy_q  <= '0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            busy_q  <= busy_d;
        end
    end

    // Storage array: zeroed by the sweep, written only in RUN and never at x0.
    always_ff @(posedge clk) begin
        if (rst) begin
            regs_q[0] <= regs_q[0];
        end else if (state_q == ST_INIT) begin
            regs_q[cnt_q] <= '0;
        end else if (we_s && (writeReg != '0)) begin
            regs_q[writeReg] <= writeData;
        end else begin
            regs_q[0] <= '0;
        end
    end

    // Flatten storage for the read-port instances.
    always_comb begin
        regs_flat_s = '0;
        for (int i = 0; i < NREGS; i++) begin
            regs_flat_s[i*XLEN +: XLEN] = regs_q[i];
        end
    end

    for (genvar k = 0; k < NREAD; k++) begin : g_rd
        regfile_rd_port #(
            .XLEN  (XLEN),
            .NREGS (NREGS),
            .AW    (AW)
        ) u_rd_port (
            .run_i       (run_s),
            .regs_flat_i (regs_flat_s),
            .busy_vec_i  (busy_q),
            .raddr_i     (readReg[k*AW +: AW]),
            .we_i        (we_s),
            .waddr_i     (writeReg),
            .wdata_i     (writeData),
            .rdata_o     (readData[k*XLEN +: XLEN]),
            .rbusy_o     (readBusy[k])
        );
    end

endmodule

// File: tb/tb_regfile_mp.sv
// Directed self-checking bench for regfile_mp (32 x 32-bit, two read ports).
module tb_regfile_mp;

    localparam int XLEN  = 32;
    localparam int NREGS = 32;
    localparam int NREAD = 2;
    localparam int AW    = 5;

    logic                  clk;
    logic                  rst;
    logic                  ready;
    logic                  regWrite;
    logic [AW-1:0]         writeReg;
    logic [XLEN-1:0]       writeData;
    logic                  claim;
    logic [AW-1:0]         claimReg;
    logic [NREAD*AW-1:0]   readReg;
    logic [NREAD*XLEN-1:0] readData;
    logic [NREAD-1:0]      readBusy;

    int n_checks;
    int n_errors;
    int n_cyc;

    regfile_mp #(
        .XLEN  (XLEN),
        .NREGS (NREGS),
        .NREAD (NREAD)
    ) dut (
        .clk       (clk),
        .rst       (rst),
        .ready     (ready),
        .regWrite  (regWrite),
        .writeReg  (writeReg),
        .writeData (writeData),
        .claim     (claim),
        .claimReg  (claimReg),
        .readReg   (readReg),
        .readData  (readData),
        .readBusy  (readBusy)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check_eq(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        n_checks++;
        if (obs !== exp) begin
            n_errors++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic set_reads(input logic [AW-1:0] a0, input logic [AW-1:0] a1);
        readReg = {a1, a0};
        #1;
    endtask

    // Counts edges until ready rises, bounded so a stuck sweep still reports.
    task automatic wait_ready(output int n);
        n = 0;
        while (!ready && n < 40) begin
            tick();
            n++;
        end
    endtask

    initial begin
        n_checks  = 0;
        n_errors  = 0;
        rst       = 1'b1;
        regWrite  = 1'b0;
        writeReg  = 5'd0;
        writeData = 32'd0;
        claim     = 1'b0;
        claimReg  = 5'd0;
        readReg   = 10'd0;

        // Reset for one cycle, then idle through the sweep.
        tick();
        rst = 1'b0;
        set_reads(5'd5, 5'd31);
        check_eq("rst_ready", {63'd0, ready}, 64'd0);
        check_eq("rst_rdata", readData, 64'd0);
        check_eq("rst_rbusy", {62'd0, readBusy}, 64'd0);
        wait_ready(n_cyc);
        check_eq("sweep_len", 64'(n_cyc), 64'd32);
        check_eq("post_sweep_rdata", readData, 64'd0);

        // Write x5, read back next cycle; same-cycle bypass also visible.
        regWrite  = 1'b1;
        writeReg  = 5'd5;
        writeData = 32'hDEADBEEF;
        set_reads(5'd5, 5'd1);
        check_eq("bypass_x5", {32'd0, readData[31:0]}, 64'h0000_0000_DEAD_BEEF);
        tick();
        regWrite = 1'b0;
        #1;
        check_eq("read_x5", {32'd0, readData[31:0]}, 64'h0000_0000_DEAD_BEEF);

        // x0 writes are discarded and never bypassed.
        regWrite  = 1'b1;
        writeReg  = 5'd0;
        writeData = 32'h00001234;
        set_reads(5'd0, 5'd5);
        check_eq("x0_bypass", {32'd0, readData[31:0]}, 64'd0);
        tick();
        regWrite = 1'b0;
        #1;
        check_eq("x0_read", readData, 64'hDEAD_BEEF_0000_0000);

        // Same-cycle write of x7 seen on port 1.
        regWrite  = 1'b1;
        writeReg  = 5'd7;
        writeData = 32'hA5A5A5A5;
        set_reads(5'd5, 5'd7);
        check_eq("bypass_p1_x7", readData, 64'hA5A5_A5A5_DEAD_BEEF);
        tick();
        regWrite = 1'b0;
        #1;
        check_eq("read_p1_x7", readData, 64'hA5A5_A5A5_DEAD_BEEF);

        // Claim x3: pending next cycle, cleared combinationally by its write.
        claim    = 1'b1;
        claimReg = 5'd3;
        set_reads(5'd3, 5'd7);
        check_eq("claim_x3_same", {62'd0, readBusy}, 64'd0);
        tick();
        claim = 1'b0;
        #1;
        check_eq("claim_x3_next", {62'd0, readBusy}, 64'd1);
        regWrite  = 1'b1;
        writeReg  = 5'd3;
        writeData = 32'h00000011;
        #1;
        check_eq("write_x3_busy", {62'd0, readBusy}, 64'd0);
        check_eq("write_x3_data", {32'd0, readData[31:0]}, 64'h11);
        tick();
        regWrite = 1'b0;
        #1;
        check_eq("after_x3_busy", {62'd0, readBusy}, 64'd0);

        // Claim and write x9 together: claim wins.
        claim     = 1'b1;
        claimReg  = 5'd9;
        regWrite  = 1'b1;
        writeReg  = 5'd9;
        writeData = 32'h00000099;
        set_reads(5'd3, 5'd9);
        tick();
        claim    = 1'b0;
        regWrite = 1'b0;
        #1;
        check_eq("claim_wins_x9", {62'd0, readBusy}, 64'd2);
        check_eq("claim_wins_data", readData, 64'h0000_0099_0000_0011);

        // Re-claim a busy register, and claim x0 (must stay clear).
        claim    = 1'b1;
        claimReg = 5'd9;
        tick();
        claimReg = 5'd0;
        set_reads(5'd0, 5'd9);
        tick();
        claim = 1'b0;
        #1;
        check_eq("reclaim_x9_and_x0", {62'd0, readBusy}, 64'd2);

        // Reset mid-operation, then again at sweep count 10.
        rst = 1'b1;
        tick();
        rst = 1'b0;
        #1;
        check_eq("rst_run_ready", {63'd0, ready}, 64'd0);
        check_eq("rst_run_rbusy", {62'd0, readBusy}, 64'd0);
        for (int i = 0; i < 10; i++) begin
            tick();
        end
        regWrite  = 1'b1;
        writeReg  = 5'd20;
        writeData = 32'hFFFFFFFF;
        claim     = 1'b1;
        claimReg  = 5'd20;
        rst       = 1'b1;
        tick();
        rst = 1'b0;
        set_reads(5'd20, 5'd20);
        check_eq("init_ignore_rdata", readData, 64'd0);
        wait_ready(n_cyc);
        regWrite = 1'b0;
        claim    = 1'b0;
        set_reads(5'd5, 5'd9);
        check_eq("resweep_len", 64'(n_cyc), 64'd32);
        check_eq("resweep_busy", {62'd0, readBusy}, 64'd0);
        check_eq("resweep_rdata", readData, 64'd0);
        set_reads(5'd20, 5'd7);
        check_eq("init_write_ignored", readData, 64'd0);

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule
